// File: rtl/rstseq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rstseq_pkg
// Brief    : Shared types, constants and a width helper for the reset
//            sequencer and its synchronizers.
// Revision : 1.0 - initial release
// ============================================================================
package rstseq_pkg;

  // Width of the lock-loss debug counter.
  localparam int LOSS_CNT_W = 8;

  // Sequencer states.
  typedef enum logic [1:0] {
    WAIT_LOCK  = 2'd0,
    STABLE     = 2'd1,
    PERIPH_RUN = 2'd2,
    RUN        = 2'd3
  } state_e;

  // Counter width able to hold 0 .. max(a,b)-1; never narrower than 1 bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    if ($clog2(m) < 1) begin
      return 1;
    end
    return $clog2(m);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdc_sync_bits.sv
`default_nettype none
// ============================================================================
// Module   : cdc_sync_bits
// Brief    : STAGES-deep flop chain bringing asynchronous bits into the clk
//            domain. All flops reset asynchronously to 0.
// Revision : 1.0 - initial release
// ============================================================================
module cdc_sync_bits #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  // Shift the asynchronous input through the chain; stage 0 is the capture flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/clk_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : clk_reset_sequencer
// Brief    : Holds peripheral and CPU resets until PLL lock has been stable
//            for LOCK_CYCLES, releases peripherals then the CPU PERIPH_LEAD
//            cycles later, and drops back into reset on any lock loss.
//            Optional macro RSTSEQ_BUTTON_EN adds a debounced, active-low
//            reset button input btn_n.
// Revision : 1.0 - initial release
// ============================================================================
module clk_reset_sequencer
  import rstseq_pkg::*;
#(
  parameter int LOCK_CYCLES     = 1024,
  parameter int PERIPH_LEAD     = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pll_locked,
`ifdef RSTSEQ_BUTTON_EN
  input  logic                  btn_n,
`endif
  output logic                  periph_reset,
  output logic                  cpu_reset,
  output logic                  ready,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

  localparam int CNT_W = cnt_width(LOCK_CYCLES, PERIPH_LEAD);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] LEAD_LAST = CNT_W'(PERIPH_LEAD - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    periph_reset_q, periph_reset_d;
  logic                    cpu_reset_q, cpu_reset_d;
  logic                    ready_q, ready_d;
  logic [LOSS_CNT_W-1:0]   loss_q, loss_d;
  logic                    lock_s;
  logic                    force_wait;

  cdc_sync_bits #(
    .STAGES(SYNC_STAGES),
    .WIDTH (1)
  ) u_lock_sync (
    .clk  (clk),
    .reset(reset),
    .d_i  (pll_locked),
    .q_o  (lock_s)
  );

`ifdef RSTSEQ_BUTTON_EN
  localparam int DB_W = cnt_width(DEBOUNCE_CYCLES, 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Synchronize the inverted button so that the reset value 0 means "released".
  logic            press_s;
  logic            press_db_q;
  logic [DB_W-1:0] db_cnt_q;

  cdc_sync_bits #(
    .STAGES(SYNC_STAGES),
    .WIDTH (1)
  ) u_btn_sync (
    .clk  (clk),
    .reset(reset),
    .d_i  (~btn_n),
    .q_o  (press_s)
  );

  // Accept a new button level only after it has held for DEBOUNCE_CYCLES.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_db_q <= 1'b0;
      db_cnt_q   <= '0;
    end else if (press_s == press_db_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DB_LAST) begin
      press_db_q <= press_s;
      db_cnt_q   <= '0;
    end else begin
      db_cnt_q <= db_cnt_q + DB_W'(1);
    end
  end

  assign force_wait = press_db_q;
`else
  assign force_wait = 1'b0;
`endif

  // State, counter and registered reset outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= WAIT_LOCK;
      cnt_q          <= '0;
      periph_reset_q <= 1'b1;
      cpu_reset_q    <= 1'b1;
      ready_q        <= 1'b0;
      loss_q         <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      periph_reset_q <= periph_reset_d;
      cpu_reset_q    <= cpu_reset_d;
      ready_q        <= ready_d;
      loss_q         <= loss_d;
    end
  end

  // Next state; outputs follow the next state so cpu_reset can never be low
  // while periph_reset is high.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss_d  = loss_q;
    if (force_wait) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          cnt_d = '0;
          if (lock_s) state_d = STABLE;
        end
        STABLE: begin
          if (!lock_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == LOCK_LAST) begin
            state_d = PERIPH_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        PERIPH_RUN: begin
          if (!lock_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            if (loss_q != '1) loss_d = loss_q + LOSS_CNT_W'(1);
          end else if (cnt_q == LEAD_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_d = '0;
          if (!lock_s) begin
            state_d = WAIT_LOCK;
            if (loss_q != '1) loss_d = loss_q + LOSS_CNT_W'(1);
          end
        end
      endcase
    end
    periph_reset_d = (state_d == WAIT_LOCK) || (state_d == STABLE);
    cpu_reset_d    = (state_d != RUN);
    ready_d        = (state_d == RUN);
  end

  assign periph_reset  = periph_reset_q;
  assign cpu_reset     = cpu_reset_q;
  assign ready         = ready_q;
  assign lock_loss_cnt = loss_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_reset_sequencer
// Brief    : Directed self-checking bench for clk_reset_sequencer with
//            LOCK_CYCLES=8, PERIPH_LEAD=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=16.
//            Button tests are compiled in with RSTSEQ_BUTTON_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_reset_sequencer;

  logic       clk;
  logic       reset;
  logic       pll_locked;
  logic       periph_reset;
  logic       cpu_reset;
  logic       ready;
  logic [7:0] lock_loss_cnt;
`ifdef RSTSEQ_BUTTON_EN
  logic       btn_n;
`endif

  int n_checks;
  int n_fail;
  int exp_loss;

  clk_reset_sequencer #(
    .LOCK_CYCLES    (8),
    .PERIPH_LEAD    (4),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pll_locked   (pll_locked),
`ifdef RSTSEQ_BUTTON_EN
    .btn_n        (btn_n),
`endif
    .periph_reset (periph_reset),
    .cpu_reset    (cpu_reset),
    .ready        (ready),
    .lock_loss_cnt(lock_loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One rising edge, then settle 1 time unit before looking at outputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic pr, input logic cr, input logic rd);
    check_eq({tag, ".periph_reset"}, {31'd0, periph_reset}, {31'd0, pr});
    check_eq({tag, ".cpu_reset"},    {31'd0, cpu_reset},    {31'd0, cr});
    check_eq({tag, ".ready"},        {31'd0, ready},        {31'd0, rd});
  endtask

  // Raise lock (synchronizer already holding 0) and verify the release timing:
  // periph_reset falls on edge 11, cpu_reset/ready change on edge 15.
  task automatic run_release(input string tag);
    pll_locked = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      tick();
      check_outs($sformatf("%s.e%0d", tag, e), (e < 11), (e < 15), (e >= 15));
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    exp_loss   = 0;
    reset      = 1'b1;
    pll_locked = 1'b1;
`ifdef RSTSEQ_BUTTON_EN
    btn_n      = 1'b1;
`endif

    // Reset held with lock present: everything stays in reset.
    for (int i = 0; i < 4; i++) begin
      tick();
      check_outs($sformatf("rst_hold%0d", i), 1'b1, 1'b1, 1'b0);
      check_eq("rst_hold.loss", lock_loss_cnt, 0);
    end

    // Release reset with lock low; nothing may move.
    pll_locked = 1'b0;
    reset      = 1'b0;
    repeat (3) tick();
    check_outs("idle", 1'b1, 1'b1, 1'b0);

    run_release("seq1");

    // Lock falls in RUN: resets rise on the third edge, loss count 1.
    pll_locked = 1'b0;
    tick();
    check_outs("runloss.e1", 1'b0, 1'b0, 1'b1);
    tick();
    check_outs("runloss.e2", 1'b0, 1'b0, 1'b1);
    tick();
    check_outs("runloss.e3", 1'b1, 1'b1, 1'b0);
    exp_loss = 1;
    check_eq("runloss.loss", lock_loss_cnt, exp_loss);

    // Glitch in STABLE seen by the FSM at cnt=5: no loss count, full restart.
    pll_locked = 1'b1;
    repeat (6) tick();
    pll_locked = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_outs($sformatf("glitch%0d", i), 1'b1, 1'b1, 1'b0);
    end
    check_eq("glitch.loss", lock_loss_cnt, exp_loss);
    run_release("seq_relock");

    // Leave RUN (counts a loss), then lose lock during PERIPH_RUN.
    pll_locked = 1'b0;
    repeat (3) tick();
    exp_loss = 2;
    check_eq("leave_run.loss", lock_loss_cnt, exp_loss);
    pll_locked = 1'b1;
    repeat (11) tick();
    pll_locked = 1'b0;
    tick();
    tick();
    check_outs("prloss.e13", 1'b0, 1'b1, 1'b0);
    tick();
    check_outs("prloss.e14", 1'b1, 1'b1, 1'b0);
    exp_loss = 3;
    check_eq("prloss.loss", lock_loss_cnt, exp_loss);
    run_release("seq_after_pr");

    // Asynchronous reset pulse mid-PERIPH_RUN, between clock edges.
    pll_locked = 1'b0;
    repeat (3) tick();
    pll_locked = 1'b1;
    repeat (12) tick();
    check_outs("pre_arst", 1'b0, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_outs("arst", 1'b1, 1'b1, 1'b0);
    check_eq("arst.loss", lock_loss_cnt, 0);
    #2;
    reset    = 1'b0;
    exp_loss = 0;
    run_release("seq_after_arst");

`ifdef RSTSEQ_BUTTON_EN
    // Short press is filtered.
    btn_n = 1'b0;
    repeat (10) tick();
    btn_n = 1'b1;
    repeat (30) tick();
    check_outs("btn_short", 1'b0, 1'b0, 1'b1);
    // Long press forces reset without counting a loss.
    btn_n = 1'b0;
    repeat (20) tick();
    check_outs("btn_long", 1'b1, 1'b1, 1'b0);
    check_eq("btn_long.loss", lock_loss_cnt, exp_loss);
    repeat (10) tick();
    check_outs("btn_held", 1'b1, 1'b1, 1'b0);
    btn_n = 1'b1;
    begin
      int waited;
      waited = 0;
      while (!ready && waited < 100) begin
        tick();
        waited++;
      end
      check_eq("btn_rerun.ready", {31'd0, ready}, 32'd1);
      check_eq("btn_rerun.periph_reset", {31'd0, periph_reset}, 32'd0);
    end
`endif

    // Repeated RUN losses: counter saturates at 255.
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      repeat (3) tick();
      exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
      check_eq($sformatf("sat%0d.loss", i), lock_loss_cnt, exp_loss);
      check_outs($sformatf("sat%0d", i), 1'b1, 1'b1, 1'b0);
      pll_locked = 1'b1;
      repeat (15) tick();
      check_outs($sformatf("sat%0d.run", i), 1'b0, 1'b0, 1'b1);
    end
    check_eq("sat.final", lock_loss_cnt, 255);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clk_reset_sequencer.md
Name: clk_reset_sequencer

Overview:
- Sits directly downstream of femtoPLL and consumes its generated `clk` plus the PLL lock indication.
- Holds peripheral and CPU reset asserted until lock has been stable for a programmable time.
- Releases peripherals first and the CPU a fixed number of cycles later.
- Re-enters reset on any loss of lock and counts those losses for debug.

Parameters:
- LOCK_CYCLES, 1024: consecutive cycles of synchronized lock required before peripheral release (>=1).
- PERIPH_LEAD, 16: cycles between peripheral release and CPU release (>=1).
- SYNC_STAGES, 2: synchronizer depth for asynchronous inputs (>=2).
- DEBOUNCE_CYCLES, 65536: button stable-time; used only with the optional feature.

Ports:
- clk  in  1  system clock from femtoPLL.
- reset  in  1  asynchronous, active-high reset (power-on/global).
- pll_locked  in  1  PLL lock, asynchronous to clk.
- periph_reset  out  1  active-high reset for peripherals; registered.
- cpu_reset  out  1  active-high reset for the CPU; registered.
- ready  out  1  high when the sequence has completed (state RUN).
- lock_loss_cnt  out  8  saturating count of lock losses after peripheral release.

Behaviour:
- Reset values: periph_reset=1, cpu_reset=1, ready=0, lock_loss_cnt=0, state=WAIT_LOCK, cnt=0, synchronizer flops=0.
- Reset assertion is asynchronous. Deassertion needs no special handling: outputs stay asserted until the sequence completes, so release is inherently synchronous to clk.
- lock_s is pll_locked passed through SYNC_STAGES flops.
- cnt width is clog2(max(LOCK_CYCLES,PERIPH_LEAD)).
- States and transitions, all evaluated on the rising edge of clk:
  - WAIT_LOCK: hold cnt=0. If lock_s=1, go to STABLE.
  - STABLE: if lock_s=0, go to WAIT_LOCK with cnt=0 (no loss count). Otherwise cnt++. When cnt==LOCK_CYCLES-1, go to PERIPH_RUN with cnt=0 and periph_reset<=0.
  - PERIPH_RUN: if lock_s=0, go to WAIT_LOCK, set periph_reset<=1 and increment lock_loss_cnt. Otherwise cnt++. When cnt==PERIPH_LEAD-1, go to RUN with cpu_reset<=0 and ready<=1.
  - RUN: if lock_s=0, go to WAIT_LOCK in the same edge, set periph_reset<=1, cpu_reset<=1, ready<=0, and increment lock_loss_cnt.
- Timing from rising pll_locked:
  - periph_reset falls on edge SYNC_STAGES+1+LOCK_CYCLES, counting the first edge that samples pll_locked=1 as edge 1.
  - cpu_reset falls PERIPH_LEAD edges later.
- Timing from falling pll_locked in RUN: both resets rise on edge SYNC_STAGES+1.
- Invariant: cpu_reset=0 implies periph_reset=0. A state where the CPU runs while peripherals are in reset never occurs.
- lock_loss_cnt saturates at 255 and never wraps. It is cleared only by `reset`.
- A lock glitch shorter than one clk period is either filtered by the synchronizer or treated as a loss. In both cases it never corrupts state or produces a partial release.

Optional Feature:
- Macro: RSTSEQ_BUTTON_EN.
- Defined:
  - Adds input `btn_n` (1 bit, active-low, asynchronous).
  - btn_n passes through a SYNC_STAGES synchronizer, then a debouncer that requires the new level to be stable for DEBOUNCE_CYCLES.
  - A debounced press forces WAIT_LOCK from any state, with outputs as on lock loss except that lock_loss_cnt does not increment.
  - The block stays in WAIT_LOCK while the button is held; the sequence restarts after release.
- Undefined: port btn_n is absent, DEBOUNCE_CYCLES is ignored, and no debounce logic is built.

Decomposition:
- Package rstseq_pkg:
  - state encoding constants: WAIT_LOCK=2'd0, STABLE=2'd1, PERIPH_RUN=2'd2, RUN=2'd3;
  - counter-width helper function (clog2);
  - LOSS_CNT_W=8.
- Sub-module cdc_sync_bits: a SYNC_STAGES-deep flop chain with async reset to 0, instantiated for pll_locked and, when enabled, for btn_n.

Test Plan (LOCK_CYCLES=8, PERIPH_LEAD=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=16):
- Reset held, pll_locked=1 → periph_reset=1, cpu_reset=1, ready=0, lock_loss_cnt=0 throughout.
- Reset released, then pll_locked rises (edge 1 samples it) → periph_reset falls at edge 11, cpu_reset and ready change at edge 15.
- pll_locked drops for 3 cycles at cnt=5 in STABLE → back to WAIT_LOCK, lock_loss_cnt stays 0, full 8-cycle count restarts after relock.
- In RUN, pll_locked falls → both resets =1 and ready=0 two edges after the first low sample, lock_loss_cnt=1. Repeat 300 times → lock_loss_cnt saturates at 255.
- Async reset pulse asserted mid-PERIPH_RUN, between clock edges → outputs return to reset values immediately, with no clk edge needed.
- RSTSEQ_BUTTON_EN:
  - btn_n low for 10 cycles → ignored.
  - btn_n low for 20 cycles in RUN → both resets assert, lock_loss_cnt unchanged, full sequence reruns after release.
